// File: rtl/snake_step_sequencer.sv
// Game-step scheduler: paces game steps, sweeps bitNum over every snake segment head-first,
// commits the player direction once per step, tracks snake length and stops on gameOver.
module snake_step_sequencer #(
  parameter int TICK_DIV = 2500000,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        btnLeft,
  input  logic        btnRight,
  input  logic        grow,
  input  logic        gameOver,
  output logic [19:0] bitNum,
  output logic        segValid,
  output logic        stepDone,
  output logic        Up,
  output logic        Down,
  output logic        Left,
  output logic        Right,
  output logic [19:0] snakeLen,
  output logic        running
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SWEEP, DEAD} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [3:0]       dir, dirNext, pendDir, pendDirNext;
  logic             growPend, growPendNext;
  logic [19:0]      bitNumNext, lenNext;
  logic             segValidNext, stepDoneNext;
  logic [3:0]       btnVec;
  logic             btnAccept, lastSeg;

  // Direction vectors are {Up, Down, Left, Right}; the opposite swaps within each axis.
  function automatic logic [3:0] oppositeDir(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  function automatic logic isOneHot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  assign btnVec    = {btnUp, btnDown, btnLeft, btnRight};
  assign btnAccept = isOneHot(btnVec) && (btnVec != oppositeDir(dir));
  assign lastSeg   = (bitNum == snakeLen - 20'd1);

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    dirNext      = dir;
    pendDirNext  = pendDir;
    growPendNext = growPend;
    bitNumNext   = bitNum;
    segValidNext = segValid;
    stepDoneNext = 1'b0;
    lenNext      = snakeLen;

    if (btnAccept) pendDirNext = btnVec;
    if ((state == WAIT || state == SWEEP) && grow) growPendNext = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = WAIT;
          cntNext   = '0;
        end
      end
      WAIT: begin
        if (!pause) begin
          if (cnt == CNT_LAST) begin
            stateNext    = SWEEP;
            cntNext      = '0;
            dirNext      = pendDir;
            bitNumNext   = 20'd0;
            segValidNext = 1'b1;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
      end
      SWEEP: begin
        // A collision ends the game immediately: no step completion and no growth.
        if (gameOver) begin
          stateNext    = DEAD;
          bitNumNext   = 20'd0;
          segValidNext = 1'b0;
        end else if (lastSeg) begin
          stateNext    = WAIT;
          cntNext      = '0;
          bitNumNext   = 20'd0;
          segValidNext = 1'b0;
          stepDoneNext = 1'b1;
          growPendNext = 1'b0;
          if ((growPend || grow) && (snakeLen < 20'(MAX_LEN))) lenNext = snakeLen + 20'd1;
        end else begin
          bitNumNext = bitNum + 20'd1;
        end
      end
      DEAD: begin
        if (start) begin
          stateNext    = WAIT;
          cntNext      = '0;
          lenNext      = 20'(INIT_LEN);
          dirNext      = 4'd0;
          pendDirNext  = 4'd0;
          growPendNext = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dir      <= 4'd0;
      pendDir  <= 4'd0;
      growPend <= 1'b0;
      bitNum   <= 20'd0;
      segValid <= 1'b0;
      stepDone <= 1'b0;
      snakeLen <= 20'(INIT_LEN);
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      dir      <= dirNext;
      pendDir  <= pendDirNext;
      growPend <= growPendNext;
      bitNum   <= bitNumNext;
      segValid <= segValidNext;
      stepDone <= stepDoneNext;
      snakeLen <= lenNext;
    end
  end

  assign {Up, Down, Left, Right} = dir;
  assign running = (state == WAIT) || (state == SWEEP);

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Self-checking bench for snake_step_sequencer: fixed vector table, directed corner sequences
// and randomized stimulus, all compared against a behavioural reference model.
module tb_snake_step_sequencer;

  localparam int TICK_DIV = 4;
  localparam int INIT_LEN = 3;
  localparam int MAX_LEN  = 5;

  logic        clock = 1'b0;
  logic        reset, start, pause, btnUp, btnDown, btnLeft, btnRight, grow, gameOver;
  logic [19:0] bitNum, snakeLen;
  logic        segValid, stepDone, Up, Down, Left, Right, running;

  int checks = 0;
  int errors = 0;

  snake_step_sequencer #(.TICK_DIV(TICK_DIV), .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .grow(grow), .gameOver(gameOver), .bitNum(bitNum), .segValid(segValid),
    .stepDone(stepDone), .Up(Up), .Down(Down), .Left(Left), .Right(Right),
    .snakeLen(snakeLen), .running(running)
  );

  always #5 clock = ~clock;

  // Reference model. Modes: 0 idle, 1 waiting, 2 sweeping, 3 dead.
  // Directions as indices 0 up, 1 down, 2 left, 3 right, -1 none; opposite is idx^1.
  int mMode = 0, mWaited = 0, mSeg = 0, mLen = INIT_LEN, mDir = -1, mPend = -1;
  bit mGrowPend = 0, mStepDone = 0;

  task automatic modelClock();
    int  nb, idx, newPend;
    bit  growNow;
    logic [3:0] b;
    if (reset) begin
      mMode = 0; mWaited = 0; mSeg = 0; mLen = INIT_LEN;
      mDir = -1; mPend = -1; mGrowPend = 0; mStepDone = 0;
      return;
    end
    mStepDone = 0;
    b = {btnUp, btnDown, btnLeft, btnRight};
    nb = 0; idx = -1;
    for (int k = 0; k < 4; k++) if (b[3-k]) begin nb++; idx = k; end
    newPend = mPend;
    if (nb == 1 && !(mDir >= 0 && idx == (mDir ^ 1))) newPend = idx;
    growNow = grow && (mMode == 1 || mMode == 2);
    case (mMode)
      0: if (start) begin mMode = 1; mWaited = 0; end
      1: if (!pause) begin
           if (mWaited == TICK_DIV - 1) begin mMode = 2; mSeg = 0; mDir = mPend; end
           else mWaited++;
         end
      2: if (gameOver) begin
           mMode = 3;
         end else if (mSeg == mLen - 1) begin
           mMode = 1; mWaited = 0; mStepDone = 1;
           if ((mGrowPend || grow) && mLen < MAX_LEN) mLen++;
           mGrowPend = 0; growNow = 0;
         end else begin
           mSeg++;
         end
      default: if (start) begin
           mMode = 1; mWaited = 0; mLen = INIT_LEN; mDir = -1; newPend = -1; mGrowPend = 0;
         end
    endcase
    mPend = newPend;
    if (growNow) mGrowPend = 1;
  endtask

  function automatic logic [46:0] modelVec();
    return {(mMode == 2) ? 20'(mSeg) : 20'd0, mMode == 2, mStepDone,
            mDir == 0, mDir == 1, mDir == 2, mDir == 3, 20'(mLen), (mMode == 1 || mMode == 2)};
  endfunction

  function automatic logic [46:0] dutVec();
    return {bitNum, segValid, stepDone, Up, Down, Left, Right, snakeLen, running};
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    modelClock();
    #1;
    check("model", 64'(dutVec()), 64'(modelVec()));
  endtask

  task automatic clearInputs();
    start = 0; pause = 0; btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0;
    grow = 0; gameOver = 0;
  endtask

  task automatic waitSeg(input int idx);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (segValid && bitNum == 20'(idx)) found = 1;
      else tick();
    end
    check($sformatf("waitSeg%0d", idx), 64'(found), 64'd1);
  endtask

  // Runs until the next stepDone, reporting the highest bitNum and the live-segment count.
  task automatic runStep(output int maxBit, output int segs);
    bit done = 0;
    maxBit = -1; segs = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (segValid) begin
        segs++;
        if (int'(bitNum) > maxBit) maxBit = int'(bitNum);
      end
      if (stepDone) done = 1;
    end
    check("stepDoneSeen", 64'(done), 64'd1);
  endtask

  typedef struct {
    logic        start;
    logic [3:0]  btn;
    logic [19:0] bitNum;
    logic        segValid;
    logic        stepDone;
    logic [3:0]  dir;
    logic        running;
  } vecT;

  vecT vecs[15];

  function automatic vecT mk(logic st, logic [3:0] btn, int bn, logic sv, logic sd,
                             logic [3:0] d, logic run);
    vecT v;
    v.start = st; v.btn = btn; v.bitNum = 20'(bn); v.segValid = sv;
    v.stepDone = sd; v.dir = d; v.running = run;
    return v;
  endfunction

  initial begin
    int maxBit, segs, n;
    reset = 1; clearInputs();

    vecs[0]  = mk(1, 4'b0000, 0, 0, 0, 4'b0000, 1);
    vecs[1]  = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 1);
    vecs[2]  = mk(0, 4'b0001, 0, 0, 0, 4'b0000, 1);
    vecs[3]  = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 1);
    vecs[4]  = mk(0, 4'b0000, 0, 1, 0, 4'b0001, 1);
    vecs[5]  = mk(0, 4'b0010, 1, 1, 0, 4'b0001, 1);
    vecs[6]  = mk(0, 4'b0000, 2, 1, 0, 4'b0001, 1);
    vecs[7]  = mk(0, 4'b0000, 0, 0, 1, 4'b0001, 1);
    vecs[8]  = mk(0, 4'b0000, 0, 0, 0, 4'b0001, 1);
    vecs[9]  = mk(0, 4'b0000, 0, 0, 0, 4'b0001, 1);
    vecs[10] = mk(0, 4'b0000, 0, 0, 0, 4'b0001, 1);
    vecs[11] = mk(0, 4'b0000, 0, 1, 0, 4'b0001, 1);
    vecs[12] = mk(0, 4'b0000, 1, 1, 0, 4'b0001, 1);
    vecs[13] = mk(0, 4'b0000, 2, 1, 0, 4'b0001, 1);
    vecs[14] = mk(0, 4'b0000, 0, 0, 1, 4'b0001, 1);

    tick(); tick();
    reset = 0;
    check("rstBitNum", 64'(bitNum), 64'd0);
    check("rstSegValid", 64'(segValid), 64'd0);
    check("rstDir", 64'({Up, Down, Left, Right}), 64'd0);
    check("rstLen", 64'(snakeLen), 64'(INIT_LEN));
    check("rstRunning", 64'(running), 64'd0);

    // Basic stepping and direction commit.
    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start;
      {btnUp, btnDown, btnLeft, btnRight} = vecs[i].btn;
      tick();
      check($sformatf("vec%0d", i),
            64'({bitNum, segValid, stepDone, Up, Down, Left, Right, snakeLen, running}),
            64'({vecs[i].bitNum, vecs[i].segValid, vecs[i].stepDone, vecs[i].dir,
                 20'(INIT_LEN), vecs[i].running}));
    end
    clearInputs();

    // Growth and saturation.
    grow = 1; tick(); grow = 0;
    runStep(maxBit, segs);
    check("growSweep1Max", 64'(maxBit), 64'd2);
    check("growLen4", 64'(snakeLen), 64'd4);
    runStep(maxBit, segs);
    check("growSweep2Max", 64'(maxBit), 64'd3);
    check("growSweep2Segs", 64'(segs), 64'd4);
    for (int k = 0; k < 3; k++) begin
      grow = 1; tick(); grow = 0;
      runStep(maxBit, segs);
    end
    check("growSat", 64'(snakeLen), 64'(MAX_LEN));

    // Game over mid-sweep, then restart.
    waitSeg(1);
    gameOver = 1; tick(); gameOver = 0;
    check("deadSegValid", 64'(segValid), 64'd0);
    check("deadStepDone", 64'(stepDone), 64'd0);
    check("deadRunning", 64'(running), 64'd0);
    check("deadLenKept", 64'(snakeLen), 64'(MAX_LEN));
    start = 1; tick(); start = 0;
    check("restartLen", 64'(snakeLen), 64'(INIT_LEN));
    check("restartDir", 64'({Up, Down, Left, Right}), 64'd0);
    check("restartRunning", 64'(running), 64'd1);

    // Pause stretches WAIT by exactly its length; pause in SWEEP has no effect.
    n = 0;
    while (!segValid && n < 40) begin
      pause = (n >= 1 && n <= 10);
      tick();
      n++;
    end
    pause = 0;
    check("pauseDelay", 64'(n), 64'(TICK_DIV + 10));
    pause = 1;
    runStep(maxBit, segs);
    pause = 0;
    check("pauseSweepSegs", 64'(segs + 1), 64'(INIT_LEN));

    // Reset mid-sweep.
    waitSeg(1);
    reset = 1; tick(); reset = 0;
    check("midRst", 64'(dutVec()), 64'({20'd0, 1'b0, 1'b0, 4'b0000, 20'(INIT_LEN), 1'b0}));

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 9) == 0);
      pause    = ($urandom_range(0, 3) == 0);
      btnUp    = ($urandom_range(0, 7) == 0);
      btnDown  = ($urandom_range(0, 7) == 0);
      btnLeft  = ($urandom_range(0, 7) == 0);
      btnRight = ($urandom_range(0, 7) == 0);
      grow     = ($urandom_range(0, 14) == 0);
      gameOver = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 0; clearInputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
